// File: rtl/pic_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// pic_cmd_sequencer
//   Write-side command decoder for an 8259A-compatible PIC. Samples CPU write
//   cycles, walks the ICW1 -> ICW2 -> (ICW3) -> (ICW4) initialisation sequence
//   and then classifies OCW1/OCW2/OCW3 writes. Each accepted write latches the
//   data byte onto internal_bus and raises exactly one one-cycle strobe.
//
// Configuration macro:
//   PIC_CASCADE_EN  defined   : WAIT_ICW3 follows ICW2 when SNGL=0.
//                   undefined : no ICW3 stage, ICW3_WRITE tied low.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   chip_select_n    in   CPU CS#, active low, synchronous to clk
//   write_enable_n   in   CPU WR#, active low, synchronous to clk
//   address          in   A0
//   data_bus_in      in   CPU data byte
//   internal_bus     out  latched write data, held until the next write
//   ICW1..4_WRITE    out  one-cycle initialisation command strobes
//   OCW1..3_WRITE    out  one-cycle operation command strobes
//   init_done        out  high while in READY
//   single_mode      out  ICW1 D1 (SNGL)
//   icw4_needed      out  ICW1 D0 (IC4)
// ---------------------------------------------------------------------------
module pic_cmd_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_bus,
    output logic       ICW1_WRITE,
    output logic       ICW2_WRITE,
    output logic       ICW3_WRITE,
    output logic       ICW4_WRITE,
    output logic       OCW1_WRITE,
    output logic       OCW2_WRITE,
    output logic       OCW3_WRITE,
    output logic       init_done,
    output logic       single_mode,
    output logic       icw4_needed
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_ICW2 = 3'd1;
`ifdef PIC_CASCADE_EN
    localparam logic [2:0] WAIT_ICW3 = 3'd2;
`endif
    localparam logic [2:0] WAIT_ICW4 = 3'd3;
    localparam logic [2:0] READY     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic       r_prev_wr_n;
    logic       r_prev_cs_n;
    logic       r_armed;
    logic       r_addr;
    logic [7:0] r_data;
    logic [7:0] r_bus;
    logic       r_single;
    logic       r_icw4;

    logic       r_icw1_wr, r_icw2_wr, r_icw4_wr;
    logic       r_ocw1_wr, r_ocw2_wr, r_ocw3_wr;
    logic       w_icw1_wr, w_icw2_wr, w_icw4_wr;
    logic       w_ocw1_wr, w_ocw2_wr, w_ocw3_wr;
`ifdef PIC_CASCADE_EN
    logic       r_icw3_wr;
    logic       w_icw3_wr;
`endif

    logic       w_write_event;
    logic       w_accept;

    // WR# rising edge with CS# low on the last low sample. r_armed blocks a
    // write whose low phase straddled reset: WR# must be seen high at least
    // once after reset before any rising edge can commit.
    assign w_write_event = write_enable_n & ~r_prev_wr_n & ~r_prev_cs_n & r_armed;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_icw1_wr    = 1'b0;
        w_icw2_wr    = 1'b0;
        w_icw4_wr    = 1'b0;
        w_ocw1_wr    = 1'b0;
        w_ocw2_wr    = 1'b0;
        w_ocw3_wr    = 1'b0;
`ifdef PIC_CASCADE_EN
        w_icw3_wr    = 1'b0;
`endif
        if (w_write_event) begin
            if (!r_addr && r_data[4]) begin
                // ICW1 restarts initialisation from any state
                w_icw1_wr    = 1'b1;
                w_accept     = 1'b1;
                w_next_state = WAIT_ICW2;
            end else begin
                case (r_state)
                    WAIT_ICW2: if (r_addr) begin
                        w_icw2_wr = 1'b1;
                        w_accept  = 1'b1;
`ifdef PIC_CASCADE_EN
                        if (!r_single)   w_next_state = WAIT_ICW3;
                        else if (r_icw4) w_next_state = WAIT_ICW4;
                        else             w_next_state = READY;
`else
                        if (r_icw4)      w_next_state = WAIT_ICW4;
                        else             w_next_state = READY;
`endif
                    end
`ifdef PIC_CASCADE_EN
                    WAIT_ICW3: if (r_addr) begin
                        w_icw3_wr = 1'b1;
                        w_accept  = 1'b1;
                        if (r_icw4) w_next_state = WAIT_ICW4;
                        else        w_next_state = READY;
                    end
`endif
                    WAIT_ICW4: if (r_addr) begin
                        w_icw4_wr    = 1'b1;
                        w_accept     = 1'b1;
                        w_next_state = READY;
                    end
                    READY: begin
                        // D4=0 here: D4=1 with A0=0 was taken as ICW1 above
                        w_accept = 1'b1;
                        if (r_addr)          w_ocw1_wr = 1'b1;
                        else if (!r_data[3]) w_ocw2_wr = 1'b1;
                        else                 w_ocw3_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_prev_wr_n <= 1'b1;
            r_prev_cs_n <= 1'b1;
            r_armed     <= 1'b0;
            r_addr      <= 1'b0;
            r_data      <= '0;
            r_bus       <= '0;
            r_single    <= 1'b0;
            r_icw4      <= 1'b0;
            r_icw1_wr   <= 1'b0;
            r_icw2_wr   <= 1'b0;
            r_icw4_wr   <= 1'b0;
            r_ocw1_wr   <= 1'b0;
            r_ocw2_wr   <= 1'b0;
            r_ocw3_wr   <= 1'b0;
`ifdef PIC_CASCADE_EN
            r_icw3_wr   <= 1'b0;
`endif
        end else begin
            r_prev_wr_n <= write_enable_n;
            r_prev_cs_n <= chip_select_n;
            if (write_enable_n) r_armed <= 1'b1;
            if (!chip_select_n && !write_enable_n) begin
                r_addr <= address;
                r_data <= data_bus_in;
            end
            r_state   <= w_next_state;
            r_icw1_wr <= w_icw1_wr;
            r_icw2_wr <= w_icw2_wr;
            r_icw4_wr <= w_icw4_wr;
            r_ocw1_wr <= w_ocw1_wr;
            r_ocw2_wr <= w_ocw2_wr;
            r_ocw3_wr <= w_ocw3_wr;
`ifdef PIC_CASCADE_EN
            r_icw3_wr <= w_icw3_wr;
`endif
            if (w_accept) r_bus <= r_data;
            if (w_icw1_wr) begin
                r_single <= r_data[1];
                r_icw4   <= r_data[0];
            end
        end
    end

    assign internal_bus = r_bus;
    assign ICW1_WRITE   = r_icw1_wr;
    assign ICW2_WRITE   = r_icw2_wr;
    assign ICW4_WRITE   = r_icw4_wr;
    assign OCW1_WRITE   = r_ocw1_wr;
    assign OCW2_WRITE   = r_ocw2_wr;
    assign OCW3_WRITE   = r_ocw3_wr;
`ifdef PIC_CASCADE_EN
    assign ICW3_WRITE   = r_icw3_wr;
`else
    assign ICW3_WRITE   = 1'b0;
`endif
    assign init_done    = (r_state == READY);
    assign single_mode  = r_single;
    assign icw4_needed  = r_icw4;

endmodule
